sprite_compositor: RTL

- Pixel source that drives the 12-bit bbbb_gggg_rrrr pixel bus of the VGA controller.
- Composites up to 4 sprites (32x32, keyed transparency) over a programmable background colour.
- During each line's left blanking interval, prefetches the sprite rows for the current line from an external synchronous sprite ROM into internal line buffers.
- Game logic programs sprite position/enable through a shadow register port; shadow values take effect at frame start.

---
 rtl/sprite_compositor.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module   : sprite_compositor
// Purpose  : Composites up to four 32x32 keyed sprites over a programmable
//            background colour onto the 12-bit bbbb_gggg_rrrr VGA pixel bus.
//            Sprite rows for the current line are prefetched from an external
//            synchronous ROM during left blanking. Position/enable/background
//            are written to shadow registers and committed at frame start.
// Options  : define COLLISION_EN to add a sticky sprite-collision flag.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_compositor #(
    parameter logic [11:0] KEY_COLOR = 12'hF0F,
    parameter logic [11:0] BG_RESET  = 12'h000,
    parameter int          ROM_AW    = 12
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              hs,
    input  logic              rdn,
    input  logic [8:0]        row_addr,
    input  logic [9:0]        col_addr,
    output logic [11:0]       d_out,
    input  logic              spr_we,
    input  logic [1:0]        spr_idx,
    input  logic [9:0]        spr_x,
    input  logic [8:0]        spr_y,
    input  logic              spr_on,
    input  logic              bg_we,
    input  logic [11:0]       bg_color,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic              fetch_busy,
    output logic              frame_tick
`ifdef COLLISION_EN
    ,
    output logic              collision
`endif
);

    localparam int c_NSPR = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Shadow (game-side) and active (display-side) sprite registers
    logic [9:0]        r_sh_x  [0:c_NSPR-1];
    logic [8:0]        r_sh_y  [0:c_NSPR-1];
    logic [c_NSPR-1:0] r_sh_on;
    logic [11:0]       r_sh_bg;
    logic [9:0]        r_ac_x  [0:c_NSPR-1];
    logic [8:0]        r_ac_y  [0:c_NSPR-1];
    logic [c_NSPR-1:0] r_ac_on;
    logic [11:0]       r_ac_bg;
    logic              r_frame_tick;

    // Prefetch state
    state_t            r_state;
    logic [1:0]        r_k;
    logic [4:0]        r_px;
    logic [4:0]        r_row;
    logic [8:0]        r_t;
    logic [c_NSPR-1:0] r_line_valid;
    logic [ROM_AW-1:0] r_rom_addr;
    logic [11:0]       r_linebuf [0:c_NSPR-1][0:31];

    logic              r_hs;
    logic              w_trig;
    logic [8:0]        w_dy;
    logic              w_on_line;

    logic [c_NSPR-1:0] w_opaque;
    logic [11:0]       w_pix_k [0:c_NSPR-1];
    logic [11:0]       w_d_out;

    // Sprite k bitmap starts at k*1024; each sprite row is 32 words
    function automatic logic [ROM_AW-1:0] f_addr(input logic [1:0] k,
                                                 input logic [4:0] row,
                                                 input logic [4:0] px);
        return ROM_AW'({k, row, px});
    endfunction

    assign w_trig    = r_hs & ~hs;
    assign w_dy      = r_t - r_ac_y[r_k];
    assign w_on_line = r_ac_on[r_k] && (w_dy < 9'd32);

    // Delay hs by one cycle to detect its falling edge
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_hs <= 1'b0;
        end else begin
            r_hs <= hs;
        end
    end

    // Shadow register writes and frame-start commit into the active set
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_NSPR; i++) begin
                r_sh_x[i] <= '0;
                r_sh_y[i] <= '0;
                r_ac_x[i] <= '0;
                r_ac_y[i] <= '0;
            end
            r_sh_on      <= '0;
            r_ac_on      <= '0;
            r_sh_bg      <= BG_RESET;
            r_ac_bg      <= BG_RESET;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            if (spr_we) begin
                r_sh_x[spr_idx]  <= spr_x;
                r_sh_y[spr_idx]  <= spr_y;
                r_sh_on[spr_idx] <= spr_on;
            end
            if (bg_we) begin
                r_sh_bg <= bg_color;
            end
            // Commit reads the pre-write shadow, so a same-cycle write waits a frame
            if (w_trig && (row_addr == 9'd0)) begin
                for (int i = 0; i < c_NSPR; i++) begin
                    r_ac_x[i] <= r_sh_x[i];
                    r_ac_y[i] <= r_sh_y[i];
                end
                r_ac_on      <= r_sh_on;
                r_ac_bg      <= r_sh_bg;
                r_frame_tick <= 1'b1;
            end
        end
    end

    // Prefetch FSM: scan each sprite, fetch its 32-word row if on this line
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_k          <= '0;
            r_px         <= '0;
            r_row        <= '0;
            r_t          <= '0;
            r_line_valid <= '0;
            r_rom_addr   <= '0;
        end else if (w_trig) begin
            // A trigger always (re)starts at sprite 0; an overrun drops stale rows
            r_t     <= row_addr;
            r_k     <= '0;
            r_state <= ST_SCAN;
            if (r_state != ST_IDLE) begin
                r_line_valid <= '0;
            end
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (w_on_line) begin
                        r_state    <= ST_FETCH;
                        r_px       <= '0;
                        r_row      <= w_dy[4:0];
                        r_rom_addr <= f_addr(r_k, w_dy[4:0], 5'd0);
                    end else begin
                        r_line_valid[r_k] <= 1'b0;
                        if (r_k == 2'd3) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_k <= r_k + 2'd1;
                        end
                    end
                end
                ST_FETCH: begin
                    r_px <= r_px + 5'd1;
                    if (r_px == 5'd31) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_rom_addr <= f_addr(r_k, r_row, r_px + 5'd1);
                    end
                end
                ST_DRAIN: begin
                    r_line_valid[r_k] <= 1'b1;
                    if (r_k == 2'd3) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_k     <= r_k + 2'd1;
                        r_state <= ST_SCAN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ROM data lags its address by one cycle, so store it one slot behind px
    always_ff @(posedge vga_clk) begin
        if ((r_state == ST_FETCH) && (r_px != 5'd0)) begin
            r_linebuf[r_k][r_px - 5'd1] <= rom_data;
        end else if (r_state == ST_DRAIN) begin
            r_linebuf[r_k][31] <= rom_data;
        end
    end

    // Per-sprite hit test with modulo-1024 column arithmetic for wrap-around
    genvar g;
    generate
        for (g = 0; g < c_NSPR; g++) begin : g_spr
            logic [9:0]  w_dx;
            logic [11:0] w_pix;
            assign w_dx        = col_addr - r_ac_x[g];
            assign w_pix       = r_linebuf[g][w_dx[4:0]];
            assign w_pix_k[g]  = w_pix;
            assign w_opaque[g] = r_line_valid[g] && (w_dx < 10'd32) && (w_pix != KEY_COLOR);
        end
    endgenerate

    // Lowest-index opaque sprite wins, background otherwise
    always_comb begin
        w_d_out = r_ac_bg;
        for (int i = c_NSPR - 1; i >= 0; i--) begin
            if (w_opaque[i]) begin
                w_d_out = w_pix_k[i];
            end
        end
    end

    assign d_out      = w_d_out;
    assign rom_addr   = r_rom_addr;
    assign fetch_busy = (r_state != ST_IDLE);
    assign frame_tick = r_frame_tick;

`ifdef COLLISION_EN
    logic w_multi;
    logic r_collision;

    assign w_multi = ((w_opaque & (w_opaque - 4'd1)) != 4'd0);

    // Sticky overlap flag; a new overlap outranks the frame-start clear
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_collision <= 1'b0;
        end else if (!rdn && w_multi) begin
            r_collision <= 1'b1;
        end else if (r_frame_tick) begin
            r_collision <= 1'b0;
        end
    end

    assign collision = r_collision;
`else
    // The read strobe only matters to the collision detector
    logic w_unused_rdn;
    assign w_unused_rdn = rdn;
`endif

endmodule
`default_nettype wire
